// File: rtl/nexys_starship_monster_sched.sv
// Nexys Starship enemy scheduler: spawns monsters into four directional slots,
// times each monster, and arbitrates the shoot buttons onto one laser.
module nexys_starship_monster_sched #(
  parameter int unsigned SPAWN_PERIOD    = 50_000_000,
  parameter int unsigned MONSTER_TIMEOUT = 150_000_000,
  parameter logic [7:0]  LFSR_SEED       = 8'h01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       q_Play,
  input  logic [3:0] shoot_req,
  output logic [3:0] monster_active,
  output logic       laser_valid,
  output logic [1:0] laser_dir,
  output logic [7:0] score,
  output logic       gameover_ctrl
);

  localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int TIMER_W = $clog2(MONSTER_TIMEOUT + 1);
  localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(MONSTER_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [SPAWN_W-1:0]   spawn_cnt, spawn_cnt_nxt;
  logic [7:0]           lfsr, lfsr_nxt;
  logic [1:0]           rr_ptr, rr_ptr_nxt;
  logic [TIMER_W-1:0]   timer [4];
  logic [TIMER_W-1:0]   timer_nxt [4];
  logic [3:0]           active_nxt;
  logic                 laser_valid_nxt;
  logic [1:0]           laser_dir_nxt;
  logic [7:0]           score_nxt;
  logic                 gameover_nxt;

  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic                 kill;
  logic                 spawn_attempt;
  logic                 spawn_ok;
  logic [1:0]           spawn_idx;
  logic [3:0]           expire;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Round-robin: scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (shoot_req[rr_ptr + 2'(k)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr + 2'(k);
      end
    end
  end

  // First free slot at or above the LFSR candidate, using pre-cycle occupancy.
  always_comb begin
    spawn_ok  = 1'b0;
    spawn_idx = lfsr[1:0];
    for (int k = 3; k >= 0; k--) begin
      if (!monster_active[lfsr[1:0] + 2'(k)]) begin
        spawn_ok  = 1'b1;
        spawn_idx = lfsr[1:0] + 2'(k);
      end
    end
  end

  assign kill          = grant_valid && monster_active[grant_idx];
  assign spawn_attempt = (spawn_cnt == SPAWN_LAST);

  // A kill landing on the expiring slot in the same cycle cancels that expiry.
  always_comb begin
    expire = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      expire[i] = monster_active[i] && (timer[i] == TIMER_W'(1)) &&
                  !(kill && (grant_idx == 2'(i)));
    end
  end

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_nxt       = state;
    active_nxt      = monster_active;
    timer_nxt       = timer;
    spawn_cnt_nxt   = spawn_cnt;
    lfsr_nxt        = lfsr;
    rr_ptr_nxt      = rr_ptr;
    laser_valid_nxt = 1'b0;
    laser_dir_nxt   = laser_dir;
    score_nxt       = score;

    unique case (state)
      IDLE: begin
        if (q_Play) begin
          state_nxt     = RUN;
          active_nxt    = '0;
          spawn_cnt_nxt = '0;
          lfsr_nxt      = LFSR_SEED;
          rr_ptr_nxt    = '0;
          score_nxt     = '0;
          for (int i = 0; i < 4; i++) timer_nxt[i] = '0;
        end
      end

      RUN: begin
        if (!q_Play) begin
          state_nxt  = IDLE;
          active_nxt = '0;
          for (int i = 0; i < 4; i++) timer_nxt[i] = '0;
        end else begin
          lfsr_nxt      = lfsr_step(lfsr);
          spawn_cnt_nxt = spawn_attempt ? '0 : spawn_cnt + SPAWN_W'(1);
          for (int i = 0; i < 4; i++) begin
            if (monster_active[i]) timer_nxt[i] = timer[i] - TIMER_W'(1);
          end
          if (grant_valid) begin
            laser_valid_nxt = 1'b1;
            laser_dir_nxt   = grant_idx;
            rr_ptr_nxt      = grant_idx + 2'd1;
            if (kill) begin
              active_nxt[grant_idx] = 1'b0;
              if (score != 8'hFF) score_nxt = score + 8'd1;
            end
          end
          if (spawn_attempt && spawn_ok) begin
            active_nxt[spawn_idx] = 1'b1;
            timer_nxt[spawn_idx]  = TIMER_LOAD;
          end
          if (|expire) state_nxt = DEAD;
        end
      end

      DEAD: begin
        if (!q_Play) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign gameover_nxt = (state_nxt == DEAD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      monster_active <= '0;
      laser_valid    <= 1'b0;
      laser_dir      <= '0;
      score          <= '0;
      gameover_ctrl  <= 1'b0;
      spawn_cnt      <= '0;
      rr_ptr         <= '0;
      lfsr           <= LFSR_SEED;
      // NOTE: the timer array is only four registers, so it resets with the rest of the state.
      for (int i = 0; i < 4; i++) timer[i] <= '0;
    end else begin
      state          <= state_nxt;
      monster_active <= active_nxt;
      laser_valid    <= laser_valid_nxt;
      laser_dir      <= laser_dir_nxt;
      score          <= score_nxt;
      gameover_ctrl  <= gameover_nxt;
      spawn_cnt      <= spawn_cnt_nxt;
      rr_ptr         <= rr_ptr_nxt;
      lfsr           <= lfsr_nxt;
      for (int i = 0; i < 4; i++) timer[i] <= timer_nxt[i];
    end
  end

endmodule

// File: tb/tb_nexys_starship_monster_sched.sv
// Self-checking bench for nexys_starship_monster_sched: directed scenarios plus
// randomized play compared each cycle against a slot/expiry-time reference model.
module tb_nexys_starship_monster_sched;

  localparam int unsigned SP   = 8;
  localparam int unsigned TO   = 20;
  localparam logic [7:0]  SEED = 8'h01;

  logic       clk = 1'b0;
  logic       reset;
  logic       q_play;
  logic [3:0] shoot_req;
  logic [3:0] monster_active;
  logic       laser_valid;
  logic [1:0] laser_dir;
  logic [7:0] score;
  logic       gameover_ctrl;

  always #5 clk = ~clk;

  nexys_starship_monster_sched #(
    .SPAWN_PERIOD   (SP),
    .MONSTER_TIMEOUT(TO),
    .LFSR_SEED      (SEED)
  ) dut (
    .Clk           (clk),
    .Reset         (reset),
    .q_Play        (q_play),
    .shoot_req     (shoot_req),
    .monster_active(monster_active),
    .laser_valid   (laser_valid),
    .laser_dir     (laser_dir),
    .score         (score),
    .gameover_ctrl (gameover_ctrl)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: slots remember the absolute run cycle at which they end the game.
  typedef enum int {P_IDLE, P_RUN, P_DEAD} phase_t;
  phase_t     m_phase;
  int         m_t;
  logic [3:0] m_active;
  int         m_expire [4];
  int         m_score;
  int         m_ptr;
  logic       m_lv;
  logic [1:0] m_dir;
  logic       m_go;

  function automatic logic [7:0] lfsr_at(input int t);
    logic [7:0] q;
    q = SEED;
    for (int i = 0; i < t; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    return q;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_t      = 0;
    m_active = '0;
    m_score  = 0;
    m_ptr    = 0;
    m_lv     = 1'b0;
    m_dir    = '0;
    m_go     = 1'b0;
    for (int i = 0; i < 4; i++) m_expire[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] pre;
    logic [7:0] lf;
    int g, cand, s;
    bit dead, placed;
    m_lv = 1'b0;
    case (m_phase)
      P_IDLE: if (q_play) begin
        m_phase  = P_RUN;
        m_t      = 0;
        m_active = '0;
        m_score  = 0;
        m_ptr    = 0;
      end
      P_RUN: if (!q_play) begin
        m_phase  = P_IDLE;
        m_active = '0;
      end else begin
        pre = m_active;
        g   = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && shoot_req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g >= 0) begin
          m_lv  = 1'b1;
          m_dir = 2'(g);
          m_ptr = (g + 1) % 4;
          if (pre[g]) begin
            m_active[g] = 1'b0;
            if (m_score < 255) m_score++;
          end
        end
        dead = 0;
        for (int i = 0; i < 4; i++)
          if (pre[i] && m_expire[i] == m_t + 1 && g != i) dead = 1;
        if (m_t % SP == SP - 1) begin
          lf     = lfsr_at(m_t);
          cand   = int'(lf[1:0]);
          placed = 0;
          for (int k = 0; k < 4; k++) begin
            s = (cand + k) % 4;
            if (!placed && !pre[s]) begin
              m_active[s] = 1'b1;
              m_expire[s] = m_t + 1 + TO;
              placed      = 1;
            end
          end
        end
        m_t++;
        if (dead) begin
          m_phase = P_DEAD;
          m_go    = 1'b1;
        end
      end
      P_DEAD: if (!q_play) begin
        m_phase = P_IDLE;
        m_go    = 1'b0;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".active"}, 32'(monster_active), 32'(m_active));
    check({tag, ".lv"},     32'(laser_valid),    32'(m_lv));
    check({tag, ".dir"},    32'(laser_dir),      32'(m_dir));
    check({tag, ".score"},  32'(score),          32'(m_score));
    check({tag, ".go"},     32'(gameover_ctrl),  32'(m_go));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) model_step();
    #1;
    compare_outputs(tag);
  endtask

  task automatic shoot_tick(input logic [3:0] bits, input string tag);
    shoot_req = bits;
    tick(tag);
    shoot_req = '0;
  endtask

  task automatic run_until(input int target, input string tag);
    int guard;
    guard = 0;
    while (m_t < target && m_phase == P_RUN && guard < 1000) begin
      tick(tag);
      guard++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_play();
    do_reset();
    q_play = 1'b1;
    tick("enter_run");
  endtask

  initial begin
    int kills;
    reset     = 1'b1;
    q_play    = 1'b0;
    shoot_req = '0;
    model_reset();
    #1;
    check("reset.active", 32'(monster_active), 32'h0);
    check("reset.go",     32'(gameover_ctrl),  32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("idle");

    // Spawn schedule and game over with no shots.
    start_play();
    run_until(7, "t1");
    check("t1.c7_empty", 32'(monster_active), 32'h0);
    tick("t1");
    check("t1.c8_slot2", 32'(monster_active), 32'b0100);
    run_until(16, "t1");
    check("t1.c16_slot1", 32'(monster_active), 32'b0110);
    run_until(27, "t2");
    check("t2.c27_alive", 32'(gameover_ctrl), 32'h0);
    tick("t2");
    check("t2.c28_gameover", 32'(gameover_ctrl), 32'h1);
    shoot_tick(4'b1111, "t2_dead_shot");
    check("t2.dead_no_laser", 32'(laser_valid), 32'h0);
    for (int i = 0; i < 10; i++) tick("t2_frozen");
    check("t2.frozen_slots", 32'(monster_active), 32'b0111);
    q_play = 1'b0;
    tick("t2_leave");
    check("t2.go_cleared", 32'(gameover_ctrl), 32'h0);

    // Kill and miss.
    start_play();
    run_until(10, "t3");
    shoot_tick(4'b0100, "t3_kill");
    check("t3.kill_lv",    32'(laser_valid),    32'h1);
    check("t3.kill_dir",   32'(laser_dir),      32'h2);
    check("t3.kill_score", 32'(score),          32'h1);
    check("t3.kill_slots", 32'(monster_active), 32'h0);
    run_until(12, "t3");
    shoot_tick(4'b0001, "t3_miss");
    check("t3.miss_lv",    32'(laser_valid), 32'h1);
    check("t3.miss_score", 32'(score),       32'h1);
    tick("t3_after");
    check("t3.pulse_one", 32'(laser_valid), 32'h0);

    // Round-robin arbitration.
    start_play();
    shoot_tick(4'b1111, "t4_a");
    check("t4.first_dir", 32'(laser_dir), 32'h0);
    shoot_tick(4'b1111, "t4_b");
    check("t4.second_dir", 32'(laser_dir), 32'h1);
    shoot_tick(4'b1111, "t4_c");
    check("t4.third_dir", 32'(laser_dir), 32'h2);

    // Kill on expiry, refill above an occupied candidate, other slot expires.
    start_play();
    run_until(27, "t5");
    check("t5.c27_slots", 32'(monster_active), 32'b0111);
    shoot_tick(4'b0100, "t5_kill");
    check("t5.no_gameover", 32'(gameover_ctrl),  32'h0);
    check("t5.score",       32'(score),          32'h1);
    check("t5.c28_slots",   32'(monster_active), 32'b0011);
    run_until(32, "t5");
    check("t5.refill_up", 32'(monster_active), 32'b0111);
    run_until(36, "t5");
    check("t5.other_expiry", 32'(gameover_ctrl), 32'h1);

    // Asynchronous reset mid-run.
    start_play();
    run_until(20, "t6");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6.async_active", 32'(monster_active), 32'h0);
    check("t6.async_score",  32'(score),          32'h0);
    tick("t6_hold");
    reset = 1'b0;

    // Score saturation.
    q_play = 1'b1;
    tick("sat_enter");
    kills = 0;
    for (int c = 0; c < 4000 && kills < 260; c++) begin
      shoot_req = '0;
      if (m_phase == P_RUN && m_active != 4'b0) begin
        for (int i = 3; i >= 0; i--) if (m_active[i]) shoot_req = 4'b0001 << i;
        kills++;
      end
      tick("sat");
    end
    shoot_req = '0;
    check("sat.score", 32'(score),         32'd255);
    check("sat.alive", 32'(gameover_ctrl), 32'h0);

    // Randomized play against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_outputs("rand_rst");
      end else begin
        reset = 1'b0;
      end
      if (m_phase == P_DEAD) q_play = ($urandom_range(0, 5) != 0);
      else if ($urandom_range(0, 79) == 0) q_play = ~q_play;
      shoot_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick("rand");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nexys_starship_monster_sched.md
Name: nexys_starship_monster_sched

Overview:
- Enemy scheduler for Nexys Starship. Runs only while the game FSM reports PLAY.
- Spawns monsters into four directional slots (top/right/bottom/left) on a pseudo-random schedule and times each live monster.
- Arbitrates the four directional shoot buttons onto a single laser.
- Produces gameover_ctrl, which feeds the game FSM's PLAY->GAMEOVER transition.

Parameters:
- SPAWN_PERIOD, 50_000_000: cycles between spawn attempts (>=2).
- MONSTER_TIMEOUT, 150_000_000: cycles a monster lives before it ends the game (>=2).
- LFSR_SEED, 8'h01: LFSR reset/restart value; must be nonzero.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- q_Play  in  1  game FSM in PLAY state
- shoot_req  in  4  debounced one-cycle pulses; bit0=top, 1=right, 2=bottom, 3=left
- monster_active  out  4  slot occupied, same bit order
- laser_valid  out  1  one-cycle pulse, a shot was fired
- laser_dir  out  2  slot index of the fired shot; held between shots
- score  out  8  monsters killed this game, saturating
- gameover_ctrl  out  1  high while in DEAD

Behaviour:
- All outputs are registered.
- Reset (async, any time) clears all state: state=IDLE, monster_active=0, laser_valid=0, laser_dir=0, score=0, gameover_ctrl=0, slot timers=0, spawn counter=0, RR pointer=0, lfsr=LFSR_SEED.

FSM:
- States: IDLE, RUN, DEAD.
- IDLE->RUN when q_Play=1. On entry: score, slots, spawn counter and RR pointer clear; lfsr=LFSR_SEED.
- The first RUN cycle is cycle 0.
- RUN->DEAD on a slot expiry. RUN->IDLE if q_Play falls, which clears slots; score is held.
- DEAD: gameover_ctrl=1. Spawning, timers and shots are frozen; score and slots are held for display.
- DEAD->IDLE when q_Play=0; gameover_ctrl=0 from then on.

LFSR:
- 8-bit, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
- Equals the seed in cycle 0 and advances every RUN cycle.

Spawn:
- Counter runs 0..SPAWN_PERIOD-1 and wraps; attempts occur when it equals SPAWN_PERIOD-1.
- Candidate slot = lfsr[1:0] in that cycle.
- If the candidate is occupied, search upward mod 4 for the first free slot. If all four are occupied, the attempt is dropped.
- The chosen slot's monster_active bit rises the next cycle, and its timer loads MONSTER_TIMEOUT.
- Occupancy is the pre-cycle value: a slot killed in the same cycle counts as occupied.

Timer:
- Each active slot decrements its timer once per cycle.
- A slot whose bit rose at cycle r expires at cycle r+MONSTER_TIMEOUT, when gameover_ctrl rises, unless it was killed.

Shoot arbitration:
- Round-robin over shoot_req, starting at the RR pointer; one grant per cycle.
- Non-granted simultaneous pulses are dropped, not queued.
- After a grant, pointer = granted index + 1 (mod 4).
- For a request at cycle n, the following all take effect at n+1:
  - laser_valid=1 and laser_dir=granted index.
  - If that slot was active at n, its bit clears and score increments, saturating at 255.
  - A miss fires the laser without changing score.

Simultaneous events:
- A kill registered in the same cycle as that slot's expiry wins: no game over.
- Expiry of a different slot still goes to DEAD.
- A kill and a spawn into another slot in the same cycle both take effect.

Test Plan:
1. SPAWN_PERIOD=8, MONSTER_TIMEOUT=20, seed 01. Reset, then q_Play=1 -> first spawn at cycle 7 with lfsr=8E, so monster_active=4'b0100 at cycle 8. Second spawn at cycle 15 with lfsr=25, so bit1 set at cycle 16.
2. Same setup, no shots -> gameover_ctrl rises at cycle 28, state DEAD. Spawns stop. Shots in DEAD give no laser_valid. Dropping q_Play -> gameover_ctrl=0 next cycle.
3. shoot_req=4'b0100 at cycle 10 -> laser_valid=1, laser_dir=2, slot 2 cleared and score=1 at cycle 11. A later shot at an empty slot -> laser_valid pulses, score unchanged.
4. shoot_req=4'b1111 for one cycle, RR pointer=0 -> only dir 0 is granted and the pointer becomes 1. Next 4'b1111 -> dir 1 is granted.
5. Kill slot 2 at cycle 27, exactly on its expiry -> no game over, score=1. All four slots full at a spawn attempt -> no change. Candidate occupied -> next free slot upward is filled.
6. Assert Reset mid-RUN with slots active -> all outputs are 0 immediately. Score saturation: 256 kills -> score holds at 255.
